// File: rtl/zamek_pkg.sv
// Shared constants, state encoding and key decode helpers for the code-lock controller.
package zamek_pkg;

    localparam int unsigned KEY_W   = 4;
    localparam int unsigned ENTRY_W = 16;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned STATE_W = 3;

    localparam logic [KEY_W-1:0] KEY_ENTER  = 4'hA;
    localparam logic [KEY_W-1:0] KEY_CANCEL = 4'hB;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_ENTRY   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SETTLE  = 3'd2;
    localparam logic [STATE_W-1:0] ST_CHECK   = 3'd3;
    localparam logic [STATE_W-1:0] ST_OPEN    = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAIL    = 3'd5;
    localparam logic [STATE_W-1:0] ST_LOCKOUT = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = ST_IDLE,
        S_ENTRY   = ST_ENTRY,
        S_SETTLE  = ST_SETTLE,
        S_CHECK   = ST_CHECK,
        S_OPEN    = ST_OPEN,
        S_FAIL    = ST_FAIL,
        S_LOCKOUT = ST_LOCKOUT
    } state_e;

    function automatic logic is_digit(input logic [KEY_W-1:0] key);
        return key <= KEY_W'(9);
    endfunction

endpackage

// File: rtl/zamek_if.sv
// Keypad, shift-register and actuator signals of the code-lock controller.
interface zamek_if;
    import zamek_pkg::*;

    logic               key_valid_i;
    logic [KEY_W-1:0]   key_i;
    logic [ENTRY_W-1:0] entry_i;
    logic               sh_ce_o;
    logic               sh_clr_o;
    logic [KEY_W-1:0]   sh_data_o;
    logic               unlock_o;
    logic               fail_o;
    logic [CNT_W-1:0]   digit_cnt_o;
    logic               locked_out_o;

    modport master (
        output key_valid_i, key_i, entry_i,
        input  sh_ce_o, sh_clr_o, sh_data_o, unlock_o, fail_o, digit_cnt_o, locked_out_o
    );

    modport slave (
        input  key_valid_i, key_i, entry_i,
        output sh_ce_o, sh_clr_o, sh_data_o, unlock_o, fail_o, digit_cnt_o, locked_out_o
    );

endinterface

// File: rtl/zamek_timer.sv
// Loadable down-counter shared by the open, fail and lockout hold phases.
module zamek_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             done_c
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - WIDTH'(1);
        end
    end

    assign done_c = (value == WIDTH'(1));

endmodule

// File: rtl/zamek_ctrl.sv
// Code-lock sequencing controller: feeds the digit shift register, checks the entry,
// holds unlock/fail. Define ZAMEK_LOCKOUT_EN to add the consecutive-failure lockout.
module zamek_ctrl
    import zamek_pkg::*;
#(
    parameter int unsigned        DIGITS      = 4,
    parameter logic [ENTRY_W-1:0] CODE        = 16'h1234,
    parameter int unsigned        OPEN_CYCLES = 100,
    parameter int unsigned        FAIL_CYCLES = 20,
    parameter int unsigned        MAX_TRIES   = 3,
    parameter int unsigned        LOCK_CYCLES = 1000
) (
    input  logic   clk,
    input  logic   clr,
    zamek_if.slave bus
);

    localparam int unsigned HOLD_OF = (OPEN_CYCLES > FAIL_CYCLES) ? OPEN_CYCLES : FAIL_CYCLES;
    localparam int unsigned HOLD_MAX = (HOLD_OF > LOCK_CYCLES) ? HOLD_OF : LOCK_CYCLES;
    localparam int unsigned TMR_W = $clog2(HOLD_MAX + 1);

    if (DIGITS == 0 || DIGITS * KEY_W != ENTRY_W || DIGITS >= (1 << CNT_W) || MAX_TRIES == 0)
    begin : g_bad_cfg
        $error("zamek_ctrl: unsupported parameter set");
    end

    state_e           state;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_done_c;
    logic             tmr_expire_c;
    logic             in_entry_c;
    logic             key_digit_c;
    logic             key_enter_c;
    logic             key_cancel_c;
    logic             cnt_full_c;
    logic             code_ok_c;
    logic             enter_short_c;
    logic             lockout_hit_c;

    assign in_entry_c    = (state == S_IDLE) || (state == S_ENTRY);
    assign key_digit_c   = bus.key_valid_i && is_digit(bus.key_i);
    assign key_enter_c   = bus.key_valid_i && (bus.key_i == KEY_ENTER);
    assign key_cancel_c  = bus.key_valid_i && (bus.key_i == KEY_CANCEL);
    assign cnt_full_c    = (bus.digit_cnt_o == CNT_W'(DIGITS));
    assign code_ok_c     = (bus.entry_i == CODE);
    assign enter_short_c = in_entry_c && key_enter_c && !cnt_full_c;
    // A zero count also releases the hold so a zero-length phase cannot stall the FSM.
    assign tmr_expire_c  = tmr_done_c || (tmr_value == '0);

    // Timer load requests on entry to OPEN, FAIL and LOCKOUT.
    always_comb begin
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        case (state)
            S_IDLE, S_ENTRY: begin
                if (enter_short_c) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(FAIL_CYCLES);
                end
            end
            S_CHECK: begin
                tmr_load     = 1'b1;
                tmr_load_val = code_ok_c ? TMR_W'(OPEN_CYCLES) : TMR_W'(FAIL_CYCLES);
            end
            S_FAIL: begin
                if (tmr_expire_c && lockout_hit_c) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(LOCK_CYCLES);
                end
            end
            default: ;
        endcase
    end

    zamek_timer #(.WIDTH(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (clr),
        .load       (tmr_load),
        .load_value (tmr_load_val),
        .value      (tmr_value),
        .done_c     (tmr_done_c)
    );

    // Sequencing FSM; sh_ce_o and sh_clr_o are single-cycle pulses.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state           <= S_IDLE;
            bus.sh_ce_o     <= 1'b0;
            bus.sh_clr_o    <= 1'b1;
            bus.sh_data_o   <= '0;
            bus.unlock_o    <= 1'b0;
            bus.fail_o      <= 1'b0;
            bus.digit_cnt_o <= '0;
        end else begin
            bus.sh_ce_o  <= 1'b0;
            bus.sh_clr_o <= 1'b0;
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (key_digit_c) begin
                        if (!cnt_full_c) begin
                            bus.sh_data_o   <= bus.key_i;
                            bus.sh_ce_o     <= 1'b1;
                            bus.digit_cnt_o <= bus.digit_cnt_o + CNT_W'(1);
                            state           <= S_ENTRY;
                        end
                    end else if (key_enter_c) begin
                        if (cnt_full_c) begin
                            state <= S_SETTLE;
                        end else begin
                            bus.fail_o <= 1'b1;
                            state      <= S_FAIL;
                        end
                    end else if (key_cancel_c) begin
                        bus.sh_clr_o    <= 1'b1;
                        bus.digit_cnt_o <= '0;
                        state           <= S_IDLE;
                    end
                end
                S_SETTLE: state <= S_CHECK;
                S_CHECK: begin
                    if (code_ok_c) begin
                        bus.unlock_o <= 1'b1;
                        state        <= S_OPEN;
                    end else begin
                        bus.fail_o <= 1'b1;
                        state      <= S_FAIL;
                    end
                end
                S_OPEN: begin
                    if (tmr_expire_c) begin
                        bus.unlock_o    <= 1'b0;
                        bus.sh_clr_o    <= 1'b1;
                        bus.digit_cnt_o <= '0;
                        state           <= S_IDLE;
                    end
                end
                S_FAIL: begin
                    if (tmr_expire_c) begin
                        bus.fail_o      <= 1'b0;
                        bus.digit_cnt_o <= '0;
                        if (lockout_hit_c) begin
                            state <= S_LOCKOUT;
                        end else begin
                            bus.sh_clr_o <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (tmr_expire_c) begin
                        bus.sh_clr_o <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ZAMEK_LOCKOUT_EN
    localparam int unsigned FC_W = $clog2(MAX_TRIES + 1);

    logic [FC_W-1:0] fail_cnt;
    logic            fail_entry_c;
    logic            open_entry_c;
    logic            lock_exit_c;

    assign fail_entry_c  = enter_short_c || ((state == S_CHECK) && !code_ok_c);
    assign open_entry_c  = (state == S_CHECK) && code_ok_c;
    assign lock_exit_c   = (state == S_LOCKOUT) && tmr_expire_c;
    assign lockout_hit_c = (fail_cnt == FC_W'(MAX_TRIES));

    // Consecutive-failure count and the lockout indicator.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            fail_cnt         <= '0;
            bus.locked_out_o <= 1'b0;
        end else begin
            if (open_entry_c || lock_exit_c) begin
                fail_cnt <= '0;
            end else if (fail_entry_c) begin
                fail_cnt <= fail_cnt + FC_W'(1);
            end
            if ((state == S_FAIL) && tmr_expire_c && lockout_hit_c) begin
                bus.locked_out_o <= 1'b1;
            end else if (lock_exit_c) begin
                bus.locked_out_o <= 1'b0;
            end
        end
    end
`else
    assign lockout_hit_c    = 1'b0;
    assign bus.locked_out_o = 1'b0;
`endif

endmodule

// File: doc/zamek_ctrl.md
Name: zamek_ctrl

Overview:
Sequencing controller for the code-lock digit shift register (4-bit digit in, 16-bit parallel entry out, ce/clr controls). Decodes keypad events, drives the shift register's ce/clr/data, counts entered digits, compares the 16-bit entry against the programmed code, and produces unlock/fail strobes with hold timers. Sits between the keypad debouncer and the lock actuator; the shift register stays a plain datapath.

Parameters:
DIGITS, 4, digits per code (shift register depth 16 bits = DIGITS*4)
CODE, 16'h1234, unlock code; most recent digit in bits [3:0]
OPEN_CYCLES, 100, cycles unlock_o stays high
FAIL_CYCLES, 20, cycles fail_o stays high
MAX_TRIES, 3, consecutive failures before lockout (optional feature only)
LOCK_CYCLES, 1000, lockout duration (optional feature only)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
key_valid_i  in  1  one-cycle key strobe
key_i  in  4  key code: 0-9 digit, 4'hA ENTER, 4'hB CANCEL, others ignored
entry_i  in  16  parallel output of the shift register
sh_ce_o  out  1  shift-register clock enable
sh_clr_o  out  1  shift-register clear
sh_data_o  out  4  digit to shift in
unlock_o  out  1  open actuator
fail_o  out  1  wrong-code indicator
digit_cnt_o  out  3  digits entered so far (0..DIGITS)
locked_out_o  out  1  lockout active

Behaviour:
- Reset (clr high, async): state IDLE; sh_ce_o=0, sh_clr_o=1, sh_data_o=0, unlock_o=0, fail_o=0, digit_cnt_o=0, locked_out_o=0, timer=0, fail counter=0. sh_clr_o drops to 0 on the first clk edge after clr deasserts.
- All outputs registered.
- States: IDLE, ENTRY, SETTLE, CHECK, OPEN, FAIL, LOCKOUT.
- IDLE/ENTRY, digit key, digit_cnt<DIGITS: next cycle sh_data_o=key_i, sh_ce_o=1 (single-cycle pulse), digit_cnt+1, state ENTRY. The register updates at the end of that cycle; entry_i is valid 2 cycles after key_valid_i.
- Digit key with digit_cnt==DIGITS: ignored, no sh_ce_o.
- ENTER with digit_cnt==DIGITS -> SETTLE (1 cycle) -> CHECK. ENTER with digit_cnt<DIGITS (including 0 in IDLE) -> FAIL directly.
- CHECK (1 cycle): entry_i==CODE -> OPEN, timer=OPEN_CYCLES; else -> FAIL, timer=FAIL_CYCLES.
- CANCEL in IDLE/ENTRY: sh_clr_o 1-cycle pulse, digit_cnt=0, -> IDLE.
- OPEN: unlock_o=1. FAIL: fail_o=1. Timer decrements each cycle. Leaving at timer==1: output drops, sh_clr_o 1-cycle pulse, digit_cnt=0, -> IDLE. unlock_o is high exactly OPEN_CYCLES cycles; fail_o exactly FAIL_CYCLES.
- Keys in SETTLE/CHECK/OPEN/FAIL/LOCKOUT: ignored, no side effects.
- Simultaneous clr and key_valid_i: reset wins.
- Reset mid-OPEN: unlock_o drops asynchronously.

Optional Feature:
ZAMEK_LOCKOUT_EN. Defined: a consecutive-failure counter (width clog2(MAX_TRIES+1)) increments on every FAIL entry and clears on OPEN entry. A failure that brings it to MAX_TRIES goes to FAIL as usual; at FAIL end it goes to LOCKOUT instead of IDLE: locked_out_o=1 for LOCK_CYCLES, keys ignored, then counter=0, sh_clr_o pulse, -> IDLE. Undefined: no counter, LOCKOUT unreachable, locked_out_o tied 0. The port is present in both builds.

Decomposition:
- Shared package zamek_pkg:
  - state encoding (3-bit localparams)
  - KEY_ENTER=4'hA, KEY_CANCEL=4'hB
  - is_digit function (key<=9)
- One sub-module, zamek_timer: loadable down-counter with load, value, and done (==1) outputs. Sized to the maximum of OPEN_CYCLES, FAIL_CYCLES and LOCK_CYCLES; shared by OPEN, FAIL and LOCKOUT.

Test Plan:
Bench parameters: CODE=16'h1234, OPEN_CYCLES=8, FAIL_CYCLES=4, MAX_TRIES=3, LOCK_CYCLES=16; bench instantiates the real shift register.
1. Keys 1,2,3,4,ENTER, each 2 cycles apart -> four single sh_ce_o pulses, digit_cnt_o 1..4, entry_i=16'h1234, unlock_o high 8 cycles, then sh_clr_o pulse, digit_cnt_o=0.
2. Keys 1,2,3,5,ENTER -> fail_o high 4 cycles, unlock_o stays 0, register cleared afterward.
3. Keys 1,2,CANCEL,1,2,3,4,ENTER back-to-back every cycle -> sh_clr_o pulse after CANCEL, final unlock_o=1 (SETTLE absorbs the pipeline delay).
4. Keys 1,2,3,4,9,ENTER -> fifth digit ignored (no sh_ce_o), unlock_o=1. Keys 1,2,ENTER -> fail_o=1.
5. clr asserted during OPEN cycle 3 -> unlock_o=0 immediately, sh_clr_o=1, IDLE after release; keys pressed during OPEN before reset cause no sh_ce_o.
6. With ZAMEK_LOCKOUT_EN, three wrong codes -> locked_out_o high 16 cycles, a correct code entered during lockout is ignored, then 1234 unlocks. Without the macro, three wrong codes -> locked_out_o stays 0.
